// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   - XLEN / ILEN         : datapath and instruction widths
//   - DEFAULT_RESET_PC    : default first fetch address (zero, matches if_id_reg reset)
//   - DEFAULT_BUBBLE      : default "no instruction" encoding (zero, matches if_id_reg reset)
//   - fetch_state_t       : fetch FSM states (REQ, WAIT, DROP)
//   - align_pc()          : forces a PC onto a 4-byte boundary
package pipeline_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [ILEN-1:0] DEFAULT_BUBBLE   = '0;

    // REQ : free to issue a fetch
    // WAIT: one fetch outstanding, its response is wanted
    // DROP: one fetch outstanding, its response is stale and will be thrown away
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the PC, issues one word-aligned fetch at a time to instruction memory
// (valid/ready request, valid-only response) and holds the returned word with
// its fetch address and address+4 in a one-entry output buffer feeding IF/ID.
//
// Ports:
//   clock, reset                       clock (rising edge), async active-high reset
//   stall_in                           downstream cannot accept the held entry
//   redirect_valid, redirect_pc        taken branch/jump; low two PC bits ignored
//   imem_req_valid, imem_req_addr      fetch request / address (always current pc)
//   imem_req_ready                     memory accepts the request this cycle
//   imem_resp_valid, imem_resp_data    one-cycle response pulse with the fetched word
//   valid_out                          buffer holds an unconsumed instruction
//   instruction_out                    held instruction, BUBBLE when empty
//   pc_plus4_out, pc_out               fetch address + 4 / fetch address of the entry
module if_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [ILEN-1:0] BUBBLE   = DEFAULT_BUBBLE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            valid_out,
    output logic [ILEN-1:0] instruction_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] pc_out
);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] fetch_addr_reg;

    logic            consume;
    logic            req_fire;

    assign consume = valid_out && !stall_in;

    // Issue only when the buffer is empty or draining this edge, so the slot is
    // guaranteed free when the response comes back. Reset gates the request
    // combinationally so nothing leaks out while reset is held.
    assign imem_req_valid = !reset && (state_reg == REQ) && !redirect_valid &&
                            (!valid_out || !stall_in);
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= REQ;
            pc_reg          <= RESET_PC;
            fetch_addr_reg  <= '0;
            valid_out       <= 1'b0;
            instruction_out <= BUBBLE;
            pc_plus4_out    <= '0;
            pc_out          <= '0;
        end else begin
            // Entry leaves the buffer when taken downstream; pc_out/pc_plus4_out
            // keep their last value since only valid_out qualifies them.
            if (consume) begin
                valid_out       <= 1'b0;
                instruction_out <= BUBBLE;
            end

            if (redirect_valid) begin
                // Redirect beats stall: the held entry is on the wrong path.
                pc_reg          <= align_pc(redirect_pc);
                valid_out       <= 1'b0;
                instruction_out <= BUBBLE;
                unique case (state_reg)
                    // A response landing in the same cycle closes the
                    // outstanding fetch, so there is nothing left to drop.
                    WAIT:    state_reg <= imem_resp_valid ? REQ : DROP;
                    DROP:    state_reg <= DROP;
                    default: state_reg <= REQ;
                endcase
            end else begin
                unique case (state_reg)
                    REQ: begin
                        // A response here is a protocol violation and is ignored.
                        if (req_fire) begin
                            pc_reg         <= pc_reg + 64'd4;
                            fetch_addr_reg <= pc_reg;
                            state_reg      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_resp_valid) begin
                            valid_out       <= 1'b1;
                            instruction_out <= imem_resp_data;
                            pc_out          <= fetch_addr_reg;
                            pc_plus4_out    <= fetch_addr_reg + 64'd4;
                            state_reg       <= REQ;
                        end
                    end
                    DROP: begin
                        if (imem_resp_valid) begin
                            state_reg <= REQ;
                        end
                    end
                    default: state_reg <= REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [63:0] pc_plus4_out;
    logic [63:0] pc_out;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ALL_ONES_M3 = 64'hFFFF_FFFF_FFFF_FFFC;

    if_stage #(
        .RESET_PC (64'h100),
        .BUBBLE   (32'h0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_plus4_out    (pc_plus4_out),
        .pc_out          (pc_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the full output set; called 1 unit after inputs are driven.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [63:0] pcv, input logic [63:0] pc4,
                           input logic rv, input logic [63:0] ra);
        chk({tag, ".valid"}, {63'd0, valid_out}, {63'd0, v});
        chk({tag, ".instr"}, {32'd0, instruction_out}, {32'd0, ins});
        chk({tag, ".pc"}, pc_out, pcv);
        chk({tag, ".pc4"}, pc_plus4_out, pc4);
        chk({tag, ".reqv"}, {63'd0, imem_req_valid}, {63'd0, rv});
        chk({tag, ".reqa"}, imem_req_addr, ra);
    endtask

    initial begin
        reset           = 1'b1;
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #2;
        chk_out("rst", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 64'h100);
        tick(); tick();

        // First request the cycle reset drops.
        reset = 1'b0;
        #1 chk_out("c0", 1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 64'h100);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_0001;
        #1 chk("c1.reqv", {63'd0, imem_req_valid}, 64'd0);
        tick();
        imem_resp_valid = 1'b0;
        #1 chk_out("c2", 1'b1, 32'h1111_0001, 64'h100, 64'h104, 1'b1, 64'h104);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_0002;
        #1 chk_out("c3", 1'b0, 32'h0, 64'h100, 64'h104, 1'b0, 64'h108);
        tick();
        imem_resp_valid = 1'b0;

        // Stall five cycles with a full buffer.
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk_out($sformatf("stall%0d", i), 1'b1, 32'h1111_0002, 64'h104, 64'h108,
                       1'b0, 64'h108);
            tick();
        end
        stall_in = 1'b0;
        #1 chk_out("unstall", 1'b1, 32'h1111_0002, 64'h104, 64'h108, 1'b1, 64'h108);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_0003;
        tick();
        imem_resp_valid = 1'b0;
        #1 chk_out("c3rd", 1'b1, 32'h1111_0003, 64'h108, 64'h10C, 1'b1, 64'h10C);

        // Redirect from REQ to 0x200: no request this cycle.
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        #1 chk("rq.reqv", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1 chk_out("r200", 1'b0, 32'h0, 64'h108, 64'h10C, 1'b1, 64'h200);
        tick();

        // 0x200 outstanding; redirect to 0x403 -> DROP.
        redirect_valid = 1'b1; redirect_pc = 64'h403;
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_0200;
        #1 chk_out("drop", 1'b0, 32'h0, 64'h108, 64'h10C, 1'b0, 64'h400);
        tick();
        imem_resp_valid = 1'b0;
        #1 chk_out("r400", 1'b0, 32'h0, 64'h108, 64'h10C, 1'b1, 64'h400);
        tick();

        // 0x400 outstanding; redirect to 0x800 coincides with the response.
        redirect_valid = 1'b1; redirect_pc = 64'h800;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_0400;
        tick();
        redirect_valid = 1'b0; imem_resp_valid = 1'b0;
        #1 chk_out("r800", 1'b0, 32'h0, 64'h108, 64'h10C, 1'b1, 64'h800);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_0800;
        tick();
        imem_resp_valid = 1'b0;

        // Redirect while stalled with a full buffer.
        stall_in = 1'b1; redirect_valid = 1'b1; redirect_pc = ALL_ONES_M3;
        #1 chk_out("full800", 1'b1, 32'h2222_0800, 64'h800, 64'h804, 1'b0, 64'h804);
        tick();
        stall_in = 1'b0; redirect_valid = 1'b0;
        #1 chk_out("flush", 1'b0, 32'h0, 64'h800, 64'h804, 1'b1, ALL_ONES_M3);
        tick();

        // Fetch at the top of the address space; pc wraps to 0.
        imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_FFFC;
        #1 chk("wrap.reqa", imem_req_addr, 64'h0);
        tick();
        imem_resp_valid = 1'b0;
        #1 chk_out("wrap", 1'b1, 32'h3333_FFFC, ALL_ONES_M3, 64'h0, 1'b1, 64'h0);
        tick();

        // Now in WAIT for 0x0; assert reset between edges.
        #2 reset = 1'b1;
        #1 chk_out("amid", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 64'h100);
        tick();
        reset = 1'b0;
        #1 chk_out("rst2", 1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 64'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
